// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception codes, handler entry, PRId.
// Also holds the EXL state type used by the controller.
package cp0_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;
  localparam logic [31:0] PRID_VALUE    = 32'h2023_0701;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } exl_state_e;

endpackage

// File: rtl/cp0_ctrl.sv
// CP0 subset: SR, Cause, EPC and PRId, plus the interrupt/exception flush request.
// The EXL bit is the state of a two-state machine.
//   state      | meaning
//   ST_NORMAL  | EXL=0, interrupts and exceptions may be taken
//   ST_HANDLER | EXL=1, inside the handler, new requests ignored until eret
module cp0_ctrl
  import cp0_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] rdata
);

  exl_state_e  r_state;
  exl_state_e  w_state_nxt;
  logic [5:0]  r_im;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_exl;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_pc_aligned;
  logic        w_unused_pc_bits;

  assign w_exl            = (r_state == ST_HANDLER);
  assign w_int_req        = r_ie & ~w_exl & (|(hw_int & r_im));
  assign w_exc_req        = ~w_exl & (exc_code_in != EXC_INT);
  assign w_req            = (w_int_req | w_exc_req) & ~reset;
  assign w_pc_aligned     = {pc_in[31:2], 2'b00};
  assign w_unused_pc_bits = ^pc_in[1:0];

  assign req     = w_req;
  assign epc_out = (we && addr == CP0_EPC) ? wdata : r_epc;

  always_comb begin
    w_state_nxt = r_state;
    if (w_req) begin
      w_state_nxt = ST_HANDLER;
    end else if (we && addr == CP0_SR) begin
      w_state_nxt = wdata[1] ? ST_HANDLER : ST_NORMAL;
    end else if (eret) begin
      w_state_nxt = ST_NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_NORMAL;
      r_im       <= '0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ip    <= hw_int;
      // exception entry takes the cycle; a coincident mtc0 is dropped
      if (w_req) begin
        r_exc_code <= w_int_req ? EXC_INT : exc_code_in;
        r_bd       <= bd_in;
        r_epc      <= bd_in ? (w_pc_aligned - 32'd4) : w_pc_aligned;
      end else if (we) begin
        if (addr == CP0_SR) begin
          r_im <= wdata[15:10];
          r_ie <= wdata[0];
        end
        if (addr == CP0_EPC) begin
          r_epc <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CP0_SR:    rdata = {16'd0, r_im, 8'd0, w_exl, r_ie};
      CP0_CAUSE: rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
      CP0_EPC:   rdata = r_epc;
      CP0_PRID:  rdata = PRID_VALUE;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: reset, interrupt/exception entry, priority,
// handler exit, mtc0 write masking and EPC forwarding.
module tb_cp0_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] pc_in;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_val;

  cp0_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .we          (we),
    .pc_in       (pc_in),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .eret        (eret),
    .req         (req),
    .epc_out     (epc_out),
    .rdata       (rdata)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; pc_in = '0; bd_in = 1'b0;
    exc_code_in = 5'd12; hw_int = 6'h3F; eret = 1'b0;
    #2;
    check("reset_req", {31'd0, req}, 32'd0);
    we = 1'b1; addr = 5'd12; wdata = 32'hFFFF_FFFF; eret = 1'b1;
    tick();
    we = 1'b0; eret = 1'b0;
    rd(5'd12, rd_val); check("reset_sr", rd_val, 32'd0);
    rd(5'd13, rd_val); check("reset_cause", rd_val, 32'd0);
    rd(5'd14, rd_val); check("reset_epc", rd_val, 32'd0);
    rd(5'd15, rd_val); check("reset_prid", rd_val, 32'h2023_0701);
    check("reset_req_held", {31'd0, req}, 32'd0);

    // release reset, enable IM[10] and IE
    reset = 1'b0; hw_int = '0; exc_code_in = '0;
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    #1;
    check("idle_req", {31'd0, req}, 32'd0);
    tick();
    we = 1'b0;
    rd(5'd12, rd_val); check("sr_write", rd_val, 32'h0000_0401);
    hw_int = 6'b000010;
    #1;
    check("masked_int_req", {31'd0, req}, 32'd0);
    hw_int = 6'b000001; pc_in = 32'h3008; bd_in = 1'b0;
    #1;
    check("int_req", {31'd0, req}, 32'd1);
    tick();
    check("int_handler_req", {31'd0, req}, 32'd0);
    rd(5'd14, rd_val); check("int_epc", rd_val, 32'h3008);
    rd(5'd13, rd_val); check("int_cause", rd_val, 32'h0000_0400);
    rd(5'd12, rd_val); check("int_sr_exl", rd_val, 32'h0000_0403);

    // exception while in handler is ignored, then eret with interrupt pending
    exc_code_in = 5'd10; pc_in = 32'h3100;
    #1;
    check("handler_exc_req", {31'd0, req}, 32'd0);
    tick();
    exc_code_in = '0;
    rd(5'd14, rd_val); check("handler_epc_held", rd_val, 32'h3008);
    rd(5'd13, rd_val); check("handler_cause_held", rd_val, 32'h0000_0400);
    eret = 1'b1;
    #1;
    check("eret_cycle_req", {31'd0, req}, 32'd0);
    tick();
    eret = 1'b0;
    rd(5'd12, rd_val); check("eret_sr", rd_val, 32'h0000_0401);
    check("pending_int_req", {31'd0, req}, 32'd1);
    hw_int = '0;
    #1;
    check("int_dropped_req", {31'd0, req}, 32'd0);

    // eret in NORMAL does nothing
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, rd_val); check("eret_normal_sr", rd_val, 32'h0000_0401);

    // delay-slot exception
    exc_code_in = 5'd12; pc_in = 32'h3010; bd_in = 1'b1;
    #1;
    check("ds_exc_req", {31'd0, req}, 32'd1);
    tick();
    exc_code_in = '0; bd_in = 1'b0;
    rd(5'd14, rd_val); check("ds_epc", rd_val, 32'h300C);
    rd(5'd13, rd_val); check("ds_cause", rd_val, 32'h8000_0030);
    check("ds_epc_out", epc_out, 32'h300C);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // interrupt beats exception; coincident mtc0 EPC is dropped
    exc_code_in = 5'd4; hw_int = 6'b000001; pc_in = 32'h3023; bd_in = 1'b0;
    we = 1'b1; addr = 5'd14; wdata = 32'h1234;
    #1;
    check("prio_req", {31'd0, req}, 32'd1);
    check("prio_fwd", epc_out, 32'h1234);
    tick();
    we = 1'b0; exc_code_in = '0; hw_int = '0;
    rd(5'd13, rd_val); check("prio_cause", rd_val, 32'h0000_0400);
    rd(5'd14, rd_val); check("prio_epc", rd_val, 32'h3020);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // EPC forwarding and PRId/unmapped reads
    we = 1'b1; addr = 5'd14; wdata = 32'h0000_5000;
    #1;
    check("fwd_same_cycle", epc_out, 32'h0000_5000);
    tick();
    we = 1'b0;
    rd(5'd14, rd_val); check("fwd_epc_reg", rd_val, 32'h0000_5000);
    rd(5'd15, rd_val); check("prid", rd_val, 32'h2023_0701);
    rd(5'd3, rd_val);  check("unmapped_read", rd_val, 32'd0);

    // Cause and PRId are read-only; SR keeps only IM/EXL/IE
    we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    tick();
    addr = 5'd15;
    tick();
    we = 1'b0;
    rd(5'd13, rd_val); check("cause_ro", rd_val, 32'd0);
    rd(5'd15, rd_val); check("prid_ro", rd_val, 32'h2023_0701);
    we = 1'b1; addr = 5'd12; wdata = 32'hFFFF_FFFF;
    tick();
    we = 1'b0;
    rd(5'd12, rd_val); check("sr_mask", rd_val, 32'h0000_FC03);
    exc_code_in = 5'd12; hw_int = 6'h3F;
    #1;
    check("exl_sw_blocks_req", {31'd0, req}, 32'd0);

    // reset overrides in-flight requests
    exc_code_in = 5'd0;
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC01;
    tick();
    we = 1'b0;
    exc_code_in = 5'd5;
    #1;
    check("pre_reset_req", {31'd0, req}, 32'd1);
    reset = 1'b1;
    #1;
    check("reset_forces_req", {31'd0, req}, 32'd0);
    tick();
    rd(5'd12, rd_val); check("reset2_sr", rd_val, 32'd0);
    rd(5'd14, rd_val); check("reset2_epc", rd_val, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL use: reset reset, synchronous, active-high; clock clk.
REQ-002 Ports SHALL be, in order:
  clk  in  1  clock
  reset  in  1  sync active-high reset
  addr  in  5  CP0 register number for read/write
  wdata  in  32  mtc0 write data
  we  in  1  mtc0 write enable, M stage
  pc_in  in  32  PC of instruction in M stage
  bd_in  in  1  M-stage instruction sits in a delay slot
  exc_code_in  in  5  pending exception code from M stage; 0 = none
  hw_int  in  6  external interrupt lines, level-sensitive
  eret  in  1  eret in M stage
  req  out  1  flush request to all pipeline registers, including W stage
  epc_out  out  32  return address for eret
  rdata  out  32  mfc0 read data, combinational

Function
REQ-003 SHALL hold SR(12): IM[15:10], EXL[1], IE[0]; Cause(13): BD[31], IP[15:10], ExcCode[6:2]; EPC(14); PRId(15) = 32'h2023_0701, constant.
REQ-004 SHALL read all unimplemented SR/Cause bits as 0, and SHALL return 0 on rdata for any other addr.
REQ-005 SHALL treat EXL as a two-state machine: NORMAL (EXL=0) and HANDLER (EXL=1).
REQ-006 SHALL compute int_req = IE & ~EXL & |(hw_int & IM), combinationally from current register values.
REQ-007 SHALL compute exc_req = ~EXL & (exc_code_in != 0).
REQ-008 SHALL drive req = (int_req | exc_req) & ~reset, combinationally, in the same cycle.
REQ-009 When req is high, SHALL at the next clk edge:
  - set EXL=1;
  - load ExcCode with 0 if int_req is high, otherwise with exc_code_in;
  - load BD with bd_in;
  - load EPC with {pc_in[31:2],2'b00} - 4 if bd_in is high, otherwise with {pc_in[31:2],2'b00}.
REQ-010 Interrupt SHALL take priority over a simultaneous exception.
REQ-011 SHALL sample hw_int into Cause.IP on every clk edge, independent of EXL.
REQ-012 With we=1 and req=0, SHALL write wdata as follows:
  - addr 12: SR writable fields IM/EXL/IE only;
  - addr 14: EPC, full 32 bits;
  - addr 13, 15 and all others: write ignored.
REQ-013 On req=1 with we=1 in the same cycle, the exception update SHALL win and the write SHALL be dropped.
REQ-014 With eret=1 and req=0, SHALL clear EXL at the next edge (HANDLER->NORMAL).
REQ-015 An eret in NORMAL state SHALL have no effect.
REQ-016 epc_out SHALL equal wdata when we=1 and addr=14 in the same cycle; otherwise it SHALL equal EPC.
REQ-017 While in HANDLER, SHALL ignore further interrupts and exceptions: req=0, and EPC/ExcCode/BD are held.

Reset
REQ-018 While reset is high, SHALL clear SR, Cause and EPC to 0 at the clk edge; PRId keeps its constant value.
REQ-019 While reset is high, req SHALL be forced to 0; reset SHALL override we, eret and any exception in flight.

Structure
REQ-020 Shared constants SHALL live in the shared define file: CP0 register numbers 12-15, ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), handler entry 32'h0000_4180, PRId value.
REQ-021 SHALL be a single flat module with no sub-module; the 120-400 RTL-line scope does not justify a split.

Verification
REQ-022 Reset scenario: assert reset with hw_int=6'h3F and exc_code_in=12 -> req=0; rdata at addr 12, 13 and 14 reads 0.
REQ-023 Masked then enabled interrupt scenario:
  - mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then hw_int=6'b000001 with pc_in=32'h3008, bd_in=0 -> req=1 in that cycle;
  - next cycle: EPC=32'h3008, ExcCode=0, EXL=1, req=0.
REQ-024 Delay-slot exception scenario: exc_code_in=12, pc_in=32'h3010, bd_in=1 -> req=1; next cycle EPC=32'h300C, Cause=32'h8000_0030.
REQ-025 Priority scenario: exc_code_in=4 with an enabled interrupt and we=1, addr=14, wdata=32'h1234 -> ExcCode=0; EPC=pc_in, not 32'h1234.
REQ-026 Handler exit scenario:
  - in HANDLER, exc_code_in=10 -> req=0, EPC unchanged;
  - eret -> EXL=0 next cycle;
  - pending enabled hw_int -> req=1 the following cycle.
REQ-027 Forwarding scenario: we=1, addr=14, wdata=32'h0000_5000 -> epc_out=32'h5000 in the same cycle; rdata at addr 15 = 32'h2023_0701.
